branch_predict_unit: RTL and testbench
======================================

Name: branch_predict_unit

Overview:
Parametrised successor to the combinational branch unit. It resolves RISC-V conditional branches (BEQ/BNE/BLT/BGE/BLTU/BGEU) in a registered execute stage. It adds a direct-mapped branch history table (BHT) of 2-bit saturating counters, which gives fetch a taken/not-taken prediction. It flags mispredictions and keeps saturating performance counters. The block sits between fetch (lookup port) and execute/PC-select (resolve port).

Parameters:
XLEN, 32, operand and PC width
BHT_ENTRIES, 64, number of 2-bit counters; power of two, >= 2; IDX_W = log2(BHT_ENTRIES)
CNT_W, 32, width of the performance counters

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
lookup_pc  input  XLEN  fetch PC to predict
lookup_taken  output  1  combinational prediction: MSB of BHT[lookup_pc[IDX_W+1:2]]
bht_clear  input  1  synchronous clear of all BHT entries to WNT
res_valid  input  1  resolve request valid this cycle
res_pc  input  XLEN  PC of the branch being resolved
rd1  input  XLEN  rs1 operand
rd2  input  XLEN  rs2 operand
funct3  input  3  branch condition
branch  input  1  instruction is a conditional branch
res_pred_taken  input  1  prediction that fetch used for this branch
out_valid  output  1  registered res_valid
pc_src  output  1  registered actual-taken
mispredict  output  1  registered (actual != predicted) for valid branches
branch_count  output  CNT_W  resolved valid branches, saturating
mispredict_count  output  CNT_W  mispredictions, saturating

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid, pc_src, mispredict = 0
  - both counters = 0
  - every BHT entry = 2'b01 (WNT)
- Condition decode (combinational, internal):
  - 000 eq; 001 ne; 100 signed lt; 101 signed ge; 110 unsigned lt; 111 unsigned ge.
  - 010/011 are invalid and resolve as not-taken.
- actual = res_valid & branch & cond. Comparisons use full XLEN.
- Latency: resolve outputs appear one cycle after the res_valid edge; out_valid = res_valid delayed by 1 cycle.
  - When res_valid = 0, the next cycle has out_valid = 0, pc_src = 0, mispredict = 0.
- mispredict = res_valid & branch & valid_funct3 & (actual != res_pred_taken).
  - Invalid funct3 or branch = 0 gives mispredict = 0.
- BHT index = res_pc[IDX_W+1:2]. Updates only when res_valid & branch & valid_funct3:
  - taken: saturating increment (11 stays 11)
  - not-taken: saturating decrement (00 stays 00)
- Counter encoding: 00 SNT, 01 WNT, 10 WT, 11 ST. Prediction = counter[1].
- bht_clear: all entries return to 01 on the next edge. It overrides a same-cycle update. Perf counters are unaffected.
- Lookup and update to the same index in one cycle: lookup_taken reflects the pre-update value (no bypass). The new value is visible the cycle after the edge.
- branch_count increments on each valid-branch update. mispredict_count increments when mispredict is asserted. Both hold at 2^CNT_W-1.
- PC bits [1:0] and the bits above IDX_W+1 are ignored (aliasing is allowed).
- rst_n asserted mid-stream: all state clears immediately. The first resolve after rst_n deassertion behaves as from power-up.

Test Plan:
- Reset, then lookup_pc=0x100 -> lookup_taken=0. All BHT entries read 01. Counters 0.
- Resolve BEQ, rd1=rd2=0x12345678, res_pc=0x100, res_pred_taken=0:
  - next cycle: out_valid=1, pc_src=1, mispredict=1
  - BHT[0x100] becomes 10, so lookup_taken=1
  - branch_count=1, mispredict_count=1
- Saturation:
  - four taken BLT (-5 vs 10) at res_pc=0x100 -> entry 11; a fifth leaves it at 11.
  - three not-taken BGEU (1 vs 0xFFFFFFFF) -> 00; a fourth stays 00.
- Aliasing and lookup/update collision (BHT_ENTRIES=64):
  - res_pc=0x100 and 0x200 share index 0.
  - Update index 0 while lookup_pc=0x200 in the same cycle -> old value seen that cycle, new value the next cycle.
- funct3=010 with branch=1, and BEQ with branch=0 -> pc_src=0, mispredict=0, BHT unchanged, counters unchanged.
- bht_clear together with a taken update -> all entries 01 on the next cycle. Then assert rst_n low mid-resolve -> outputs 0 immediately, counters 0.

Source files
------------

// File: rtl/branch_predict_unit.sv
// Registered RISC-V conditional-branch resolver with a direct-mapped table of
// 2-bit saturating counters for fetch prediction, misprediction flag and perf counters.
module branch_predict_unit #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  lookup_pc,
    output logic             lookup_taken,
    input  logic             bht_clear,
    input  logic             res_valid,
    input  logic [XLEN-1:0]  res_pc,
    input  logic [XLEN-1:0]  rd1,
    input  logic [XLEN-1:0]  rd2,
    input  logic [2:0]       funct3,
    input  logic             branch,
    input  logic             res_pred_taken,
    output logic             out_valid,
    output logic             pc_src,
    output logic             mispredict,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);
    localparam logic [1:0]       CTR_WNT = 2'b01;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       bht_q [BHT_ENTRIES];
    logic             out_valid_q;
    logic             pc_src_q;
    logic             mispredict_q;
    logic [CNT_W-1:0] branch_cnt_q;
    logic [CNT_W-1:0] mispredict_cnt_q;

    logic [IDX_W-1:0] lookup_idx;
    logic [IDX_W-1:0] res_idx;
    logic             cond_valid;
    logic             cond_true;
    logic             upd_en;
    logic             actual_d;
    logic             mispredict_d;
    logic [1:0]       ctr_cur;
    logic [1:0]       ctr_d;
    logic             unused_pc_bits;

    assign lookup_idx = lookup_pc[IDX_W+1:2];
    assign res_idx    = res_pc[IDX_W+1:2];

    // Lookup reads the registered table only, so a same-cycle update is not bypassed.
    assign lookup_taken = bht_q[lookup_idx][1];

    assign unused_pc_bits = ^{lookup_pc[XLEN-1:IDX_W+2], lookup_pc[1:0],
                              res_pc[XLEN-1:IDX_W+2], res_pc[1:0]};

    always_comb begin
        cond_valid = 1'b1;
        cond_true  = 1'b0;
        case (funct3)
            3'b000:  cond_true = (rd1 == rd2);
            3'b001:  cond_true = (rd1 != rd2);
            3'b100:  cond_true = ($signed(rd1) <  $signed(rd2));
            3'b101:  cond_true = ($signed(rd1) >= $signed(rd2));
            3'b110:  cond_true = (rd1 <  rd2);
            3'b111:  cond_true = (rd1 >= rd2);
            default: cond_valid = 1'b0;
        endcase
    end

    assign upd_en       = res_valid & branch & cond_valid;
    assign actual_d     = res_valid & branch & cond_true;
    assign mispredict_d = upd_en & (actual_d != res_pred_taken);

    always_comb begin
        ctr_cur = bht_q[res_idx];
        ctr_d   = ctr_cur;
        if (actual_d) begin
            if (ctr_cur != 2'b11) ctr_d = ctr_cur + 2'b01;
        end else begin
            if (ctr_cur != 2'b00) ctr_d = ctr_cur - 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= CTR_WNT;
        end else if (bht_clear) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= CTR_WNT;
        end else if (upd_en) begin
            bht_q[res_idx] <= ctr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            pc_src_q     <= 1'b0;
            mispredict_q <= 1'b0;
        end else begin
            out_valid_q  <= res_valid;
            pc_src_q     <= actual_d;
            mispredict_q <= mispredict_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            if (upd_en && branch_cnt_q != CNT_MAX)
                branch_cnt_q <= branch_cnt_q + CNT_ONE;
            if (mispredict_d && mispredict_cnt_q != CNT_MAX)
                mispredict_cnt_q <= mispredict_cnt_q + CNT_ONE;
        end
    end

    assign out_valid        = out_valid_q;
    assign pc_src           = pc_src_q;
    assign mispredict       = mispredict_q;
    assign branch_count     = branch_cnt_q;
    assign mispredict_count = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: vector table for the condition decode
// plus hand sequences for counter saturation, aliasing, clear and mid-stream reset.
module tb_branch_predict_unit;

    localparam int CW = 4;
    localparam logic [CW-1:0] CMAX = '1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   lookup_pc;
    logic          lookup_taken;
    logic          bht_clear;
    logic          res_valid;
    logic [31:0]   res_pc;
    logic [31:0]   rd1;
    logic [31:0]   rd2;
    logic [2:0]    funct3;
    logic          branch;
    logic          res_pred_taken;
    logic          out_valid;
    logic          pc_src;
    logic          mispredict;
    logic [CW-1:0] branch_count;
    logic [CW-1:0] mispredict_count;

    int total = 0;
    int bad   = 0;
    logic [CW-1:0] exp_bc;
    logic [CW-1:0] exp_mc;

    branch_predict_unit #(.XLEN(32), .BHT_ENTRIES(64), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .lookup_pc(lookup_pc), .lookup_taken(lookup_taken),
        .bht_clear(bht_clear),
        .res_valid(res_valid), .res_pc(res_pc), .rd1(rd1), .rd2(rd2),
        .funct3(funct3), .branch(branch), .res_pred_taken(res_pred_taken),
        .out_valid(out_valid), .pc_src(pc_src), .mispredict(mispredict),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic        br;
        logic        pred;
        logic        exp_pc;
        logic        exp_mis;
        logic        exp_upd;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic br, input logic pred);
        res_valid      = 1'b1;
        res_pc         = pc;
        funct3         = f3;
        rd1            = a;
        rd2            = b;
        branch         = br;
        res_pred_taken = pred;
    endtask

    task automatic idle();
        res_valid      = 1'b0;
        branch         = 1'b0;
        res_pred_taken = 1'b0;
        bht_clear      = 1'b0;
    endtask

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic en);
        return (en && v != CMAX) ? v + 1'b1 : v;
    endfunction

    task automatic peek(input string nm, input logic [31:0] pc, input logic exp);
        lookup_pc = pc;
        #1;
        chk(nm, 64'(lookup_taken), 64'(exp));
    endtask

    // Every entry reads not-taken; used only while the resolve port is idle.
    task automatic scan_all_not_taken(input string nm);
        int errs = 0;
        for (int i = 0; i < 64; i++) begin
            lookup_pc = 32'(i) << 2;
            #1;
            if (lookup_taken !== 1'b0) errs++;
        end
        chk(nm, 64'(errs), 64'd0);
    endtask

    task automatic chk_out(input string nm, input logic v, input logic p, input logic m);
        chk({nm, ".out_valid"},  64'(out_valid),  64'(v));
        chk({nm, ".pc_src"},     64'(pc_src),     64'(p));
        chk({nm, ".mispredict"}, 64'(mispredict), 64'(m));
    endtask

    task automatic chk_cnt(input string nm);
        chk({nm, ".branch_count"},     64'(branch_count),     64'(exp_bc));
        chk({nm, ".mispredict_count"}, 64'(mispredict_count), 64'(exp_mc));
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        #3;
        exp_bc = '0;
        exp_mc = '0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        vecs[0]  = '{3'b001, 32'h5,        32'h5,        1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{3'b001, 32'h5,        32'h6,        1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[2]  = '{3'b100, 32'h80000000, 32'h1,        1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{3'b110, 32'h80000000, 32'h1,        1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[4]  = '{3'b101, 32'hFFFFFFFF, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[5]  = '{3'b101, 32'h7,        32'h7,        1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[6]  = '{3'b110, 32'h1,        32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{3'b111, 32'hFFFFFFFF, 32'h1,        1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{3'b000, 32'h1,        32'h80000001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{3'b011, 32'h7,        32'h7,        1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{3'b100, 32'h5,        32'h6,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{3'b111, 32'h0,        32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

        rst_n     = 1'b0;
        lookup_pc = 32'h100;
        res_pc    = '0;
        rd1       = '0;
        rd2       = '0;
        funct3    = '0;
        idle();
        exp_bc = '0;
        exp_mc = '0;
        #12;
        chk_out("reset", 1'b0, 1'b0, 1'b0);
        chk_cnt("reset");
        peek("reset.lookup_100", 32'h100, 1'b0);
        scan_all_not_taken("reset.bht_all_wnt");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // First resolve: BEQ taken, predicted not-taken
        drive(32'h100, 3'b000, 32'h12345678, 32'h12345678, 1'b1, 1'b0);
        tick();
        exp_bc = 1; exp_mc = 1;
        chk_out("beq1", 1'b1, 1'b1, 1'b1);
        chk_cnt("beq1");
        peek("beq1.lookup", 32'h100, 1'b1);
        idle();
        tick();
        chk_out("idle", 1'b0, 1'b0, 1'b0);

        // Taken saturation: entry goes 10 -> 11 and stays there
        for (int k = 0; k < 5; k++) begin
            drive(32'h100, 3'b100, 32'hFFFFFFFB, 32'd10, 1'b1, 1'b1);
            tick();
            exp_bc = sat_inc(exp_bc, 1'b1);
            chk_out("blt_sat", 1'b1, 1'b1, 1'b0);
            peek("blt_sat.lookup", 32'h100, 1'b1);
        end
        // Not-taken: 11 -> 10 -> 01 -> 00 -> 00
        for (int k = 0; k < 4; k++) begin
            drive(32'h100, 3'b111, 32'h1, 32'hFFFFFFFF, 1'b1, 1'b0);
            tick();
            exp_bc = sat_inc(exp_bc, 1'b1);
            chk_out("bgeu_sat", 1'b1, 1'b0, 1'b0);
            peek("bgeu_sat.lookup", 32'h100, (k == 0));
        end
        chk_cnt("sat");
        // From a floored 00, one taken reaches only 01
        drive(32'h100, 3'b000, 32'h3, 32'h3, 1'b1, 1'b0);
        tick();
        exp_bc = sat_inc(exp_bc, 1'b1);
        exp_mc = sat_inc(exp_mc, 1'b1);
        peek("floor.lookup", 32'h100, 1'b0);

        // Alias 0x200 onto index 0 and observe no bypass during the update cycle
        drive(32'h100, 3'b000, 32'h9, 32'h9, 1'b1, 1'b0);
        lookup_pc = 32'h200;
        @(posedge clk);
        chk("collide.old", 64'(lookup_taken), 64'd0);
        #1;
        exp_bc = sat_inc(exp_bc, 1'b1);
        exp_mc = sat_inc(exp_mc, 1'b1);
        chk("collide.new", 64'(lookup_taken), 64'd1);
        peek("collide.other_idx", 32'h104, 1'b0);
        chk_cnt("collide");

        // Invalid funct3 and non-branch leave everything untouched
        drive(32'h100, 3'b010, 32'h9, 32'h9, 1'b1, 1'b0);
        tick();
        chk_out("f3_010", 1'b1, 1'b0, 1'b0);
        drive(32'h100, 3'b000, 32'h9, 32'h9, 1'b0, 1'b0);
        tick();
        chk_out("nobranch", 1'b1, 1'b0, 1'b0);
        chk_cnt("invalid");
        idle();
        peek("invalid.bht", 32'h100, 1'b1);

        // Clear wins over a same-cycle taken update; counters still advance
        drive(32'h14, 3'b000, 32'h9, 32'h9, 1'b1, 1'b1);
        tick();
        exp_bc = sat_inc(exp_bc, 1'b1);
        peek("pre_clear.idx5", 32'h14, 1'b1);
        drive(32'h100, 3'b000, 32'h9, 32'h9, 1'b1, 1'b1);
        bht_clear = 1'b1;
        tick();
        exp_bc = sat_inc(exp_bc, 1'b1);
        chk_out("clear", 1'b1, 1'b1, 1'b0);
        chk_cnt("clear");
        idle();
        scan_all_not_taken("clear.bht_all_wnt");

        // Asynchronous reset in the middle of a resolve
        @(negedge clk);
        drive(32'h100, 3'b000, 32'h9, 32'h9, 1'b1, 1'b0);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        exp_bc = '0;
        exp_mc = '0;
        chk_out("midreset", 1'b0, 1'b0, 1'b0);
        chk_cnt("midreset");
        #1;
        rst_n = 1'b1;
        drive(32'h100, 3'b000, 32'h12345678, 32'h12345678, 1'b1, 1'b0);
        lookup_pc = 32'h100;
        tick();
        exp_bc = 1; exp_mc = 1;
        chk_out("post_reset", 1'b1, 1'b1, 1'b1);
        chk_cnt("post_reset");
        peek("post_reset.lookup", 32'h100, 1'b1);

        // Condition-decode vector table
        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive(32'h1000 + 32'(i) * 4, vecs[i].f3, vecs[i].a, vecs[i].b,
                  vecs[i].br, vecs[i].pred);
            tick();
            exp_bc = sat_inc(exp_bc, vecs[i].exp_upd);
            exp_mc = sat_inc(exp_mc, vecs[i].exp_mis);
            chk_out($sformatf("vec%0d", i), 1'b1, vecs[i].exp_pc, vecs[i].exp_mis);
        end
        chk_cnt("vec_table");

        // Perf counter saturation
        for (int k = 0; k < 13; k++) begin
            drive(32'h40, 3'b000, 32'h1, 32'h1, 1'b1, 1'b0);
            tick();
            exp_bc = sat_inc(exp_bc, 1'b1);
            exp_mc = sat_inc(exp_mc, 1'b1);
        end
        chk_cnt("cnt_sat");
        chk("cnt_sat.bc_max", 64'(branch_count), 64'(CMAX));
        chk("cnt_sat.mc_max", 64'(mispredict_count), 64'(CMAX));
        idle();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
